// File: rtl/sha256_pkg.sv
// Shared types for the SHA-256 accelerator datapath.
// Holds the transaction-ID width and the ID type.
package sha256_pkg;

  localparam int ID_W = 6;

  typedef logic [ID_W-1:0] id_t;

endpackage

// File: rtl/sha256_id_issuer.sv
// Issues sequential IDs to two consumers (cfg, buf) over
// independent valid/ready channels; an ID retires only once both accept.
// Ports:
//   clk, sync_rst (sync, active-high), en (launch enable)
//   id_out, id_out_last (always 1)
//   id_out_cfg_valid/ready : concatenator channel
//   id_out_buf_valid/ready : ID buffer channel
module sha256_id_issuer
  import sha256_pkg::*;
(
  input  logic clk,
  input  logic sync_rst,
  input  logic en,
  output id_t  id_out,
  output logic id_out_last,
  output logic id_out_cfg_valid,
  input  logic id_out_cfg_ready,
  output logic id_out_buf_valid,
  input  logic id_out_buf_ready
);

  id_t  next_id_q, next_id_d;
  id_t  id_q, id_d;
  logic cfg_v_q, cfg_v_d;
  logic buf_v_q, buf_v_d;

  logic cfg_hs, buf_hs;
  logic cfg_done, buf_done;
  logic launch;

  assign cfg_hs   = cfg_v_q & id_out_cfg_ready;
  assign buf_hs   = buf_v_q & id_out_buf_ready;
  // A channel is free when idle or accepting this cycle,
  // so simultaneous final handshakes launch with no bubble.
  assign cfg_done = ~cfg_v_q | cfg_hs;
  assign buf_done = ~buf_v_q | buf_hs;
  assign launch   = en & cfg_done & buf_done;

  always_comb begin
    next_id_d = next_id_q;
    id_d      = id_q;
    cfg_v_d   = cfg_v_q;
    buf_v_d   = buf_v_q;
    if (launch) begin
      id_d      = next_id_q;
      next_id_d = next_id_q + 1'b1;
      cfg_v_d   = 1'b1;
      buf_v_d   = 1'b1;
    end else begin
      if (cfg_hs) cfg_v_d = 1'b0;
      if (buf_hs) buf_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      next_id_q <= '0;
      id_q      <= '0;
      cfg_v_q   <= 1'b0;
      buf_v_q   <= 1'b0;
    end else begin
      next_id_q <= next_id_d;
      id_q      <= id_d;
      cfg_v_q   <= cfg_v_d;
      buf_v_q   <= buf_v_d;
    end
  end

  assign id_out           = id_q;
  assign id_out_last      = 1'b1;
  assign id_out_cfg_valid = cfg_v_q;
  assign id_out_buf_valid = buf_v_q;

endmodule

// File: tb/tb_sha256_id_issuer.sv
// Randomized self-checking bench for sha256_id_issuer.
// Transaction-level model: pending flags, next ID, per-channel counts.
module tb_sha256_id_issuer;
  import sha256_pkg::*;

  logic clk = 1'b0;
  logic sync_rst, en, cfg_ready, buf_ready;
  id_t  id_out;
  logic last, cfg_valid, buf_valid;

  sha256_id_issuer dut (
    .clk              (clk),
    .sync_rst         (sync_rst),
    .en               (en),
    .id_out           (id_out),
    .id_out_last      (last),
    .id_out_cfg_valid (cfg_valid),
    .id_out_cfg_ready (cfg_ready),
    .id_out_buf_valid (buf_valid),
    .id_out_buf_ready (buf_ready)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  int m_id, m_next, cfg_cnt, buf_cnt;
  bit m_cv, m_bv;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_id = 0; m_next = 0; m_cv = 0; m_bv = 0;
    cfg_cnt = 0; buf_cnt = 0;
  endtask

  // One clock: compare at negedge, advance model at posedge,
  // return 1ns after the edge so callers can drive new inputs.
  task automatic cycle();
    bit chs, bhs, launch;
    @(negedge clk);
    chk("id", {26'd0, id_out}, m_id);
    chk("cfg_v", {31'd0, cfg_valid}, {31'd0, m_cv});
    chk("buf_v", {31'd0, buf_valid}, {31'd0, m_bv});
    chk("last", {31'd0, last}, 1);
    chs = m_cv && cfg_ready;
    bhs = m_bv && buf_ready;
    if (!sync_rst) begin
      if (chs) begin
        chk("cfg_seq", {26'd0, id_out}, cfg_cnt % 64);
        cfg_cnt++;
      end
      if (bhs) begin
        chk("buf_seq", {26'd0, id_out}, buf_cnt % 64);
        buf_cnt++;
      end
    end
    @(posedge clk);
    if (sync_rst) begin
      model_reset();
    end else begin
      launch = en && (!m_cv || chs) && (!m_bv || bhs);
      if (launch) begin
        m_id   = m_next;
        m_next = (m_next + 1) % 64;
        m_cv   = 1;
        m_bv   = 1;
      end else begin
        if (chs) m_cv = 0;
        if (bhs) m_bv = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    sync_rst = 1; en = 1; cfg_ready = 1; buf_ready = 1;
    cycle();
    sync_rst = 0;
  endtask

  initial begin
    int cs, bs;
    sync_rst = 1; en = 0; cfg_ready = 0; buf_ready = 0;
    @(posedge clk); #1;
    model_reset();
    cycle();
    chk("rst_id", {26'd0, id_out}, 0);
    chk("rst_cfg_v", {31'd0, cfg_valid}, 0);
    chk("rst_buf_v", {31'd0, buf_valid}, 0);
    chk("rst_last", {31'd0, last}, 1);

    // 1: full throughput
    sync_rst = 0; en = 1; cfg_ready = 1; buf_ready = 1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("t1_id", {26'd0, id_out}, i);
      chk("t1_last", {31'd0, last}, 1);
    end

    // 2: buf stalled while cfg accepts id 5
    do_reset();
    for (int i = 0; i < 6; i++) cycle();
    chk("t2_at5", {26'd0, id_out}, 5);
    buf_ready = 0;
    for (int i = 0; i < 3; i++) cycle();
    chk("t2_cfg_drop", {31'd0, cfg_valid}, 0);
    chk("t2_buf_hold", {31'd0, buf_valid}, 1);
    chk("t2_hold5", {26'd0, id_out}, 5);
    buf_ready = 1;
    cycle();
    chk("t2_id6", {26'd0, id_out}, 6);
    chk("t2_cfg_v6", {31'd0, cfg_valid}, 1);

    // 3: random stalls 0..4 on each channel, random enable
    do_reset();
    cs = 0; bs = 0;
    for (int i = 0; i < 400; i++) begin
      if (cs > 0) begin cfg_ready = 0; cs--; end
      else begin cfg_ready = 1; cs = $urandom_range(0, 4); end
      if (bs > 0) begin buf_ready = 0; bs--; end
      else begin buf_ready = 1; bs = $urandom_range(0, 4); end
      en = ($urandom % 8) != 0;
      cycle();
    end
    chk("t3_progress", {31'd0, cfg_cnt > 20}, 1);
    chk("t3_balance", {31'd0, (cfg_cnt - buf_cnt) <= 1 &&
                              (buf_cnt - cfg_cnt) <= 1}, 1);

    // 4: wrap-around over 70 IDs
    do_reset();
    en = 1; cfg_ready = 1; buf_ready = 1;
    for (int i = 0; i < 70; i++) begin
      cycle();
      chk("t4_wrap", {26'd0, id_out}, i % 64);
    end

    // 5: en=0 with a pending ID
    en = 0; cfg_ready = 0; buf_ready = 0;
    for (int i = 0; i < 3; i++) cycle();
    chk("t5_cfg_hold", {31'd0, cfg_valid}, 1);
    chk("t5_buf_hold", {31'd0, buf_valid}, 1);
    chk("t5_id_hold", {26'd0, id_out}, 5);
    cfg_ready = 1; buf_ready = 1;
    cycle();
    chk("t5_cfg_clr", {31'd0, cfg_valid}, 0);
    chk("t5_buf_clr", {31'd0, buf_valid}, 0);
    for (int i = 0; i < 3; i++) cycle();
    chk("t5_no_launch", {31'd0, cfg_valid | buf_valid}, 0);
    en = 1;
    cycle();
    chk("t5_relaunch", {26'd0, id_out}, 6);

    // 6: reset with id 9 pending
    do_reset();
    en = 1; cfg_ready = 1; buf_ready = 1;
    for (int i = 0; i < 10; i++) cycle();
    chk("t6_at9", {26'd0, id_out}, 9);
    cfg_ready = 0; buf_ready = 0;
    cycle();
    sync_rst = 1; cfg_ready = 1; buf_ready = 1;
    cycle();
    chk("t6_cfg_v0", {31'd0, cfg_valid}, 0);
    chk("t6_buf_v0", {31'd0, buf_valid}, 0);
    sync_rst = 0;
    cycle();
    chk("t6_restart", {26'd0, id_out}, 0);
    chk("t6_valid", {31'd0, cfg_valid & buf_valid}, 1);
    cycle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
